// File: rtl/qnr_div_pkg.sv
// Shared types and default widths for the pipelined signed-by-unsigned divider.
package qnr_div_pkg;

    typedef enum logic {
        TRUNC = 1'b0,
        ROUND = 1'b1
    } round_mode_e;

    localparam int unsigned DEF_Z_WIDTH = 16;
    localparam int unsigned DEF_D_WIDTH = 8;
    localparam int unsigned DEF_TAG_W   = 4;

    // Per-operation flags carried next to the tag: {round_mode, dividend_neg, dividend_nonzero}.
    localparam int unsigned SB_FLAGS = 3;

endpackage

// File: rtl/qnr_div_stage.sv
// One restoring-division iteration: shifts one dividend bit into the partial remainder
// and one quotient bit into the accumulator, then registers everything on advance.
module qnr_div_stage
    import qnr_div_pkg::*;
#(
    parameter int unsigned ZW  = DEF_Z_WIDTH,
    parameter int unsigned DW  = DEF_D_WIDTH,
    parameter int unsigned SBW = DEF_TAG_W + SB_FLAGS
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           adv_i,
    input  logic           valid_i,
    input  logic [DW:0]    rem_i,
    input  logic [ZW-1:0]  acc_i,
    input  logic [DW-1:0]  divisor_i,
    input  logic [SBW-1:0] sb_i,
    output logic           valid_o,
    output logic [DW:0]    rem_o,
    output logic [ZW-1:0]  acc_o,
    output logic [DW-1:0]  divisor_o,
    output logic [SBW-1:0] sb_o
);

    logic           fits;
    logic [DW:0]    trial;
    logic           valid_d, valid_q;
    logic [DW:0]    rem_d, rem_q;
    logic [ZW-1:0]  acc_d, acc_q;
    logic [DW-1:0]  divisor_d, divisor_q;
    logic [SBW-1:0] sb_d, sb_q;

    always_comb begin
        // acc holds untouched dividend bits at the top and finished quotient bits at the bottom.
        fits  = ({rem_i, acc_i[ZW-1]} >= {2'b00, divisor_i});
        trial = {rem_i[DW-1:0], acc_i[ZW-1]} - {1'b0, divisor_i};

        valid_d   = valid_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        divisor_d = divisor_q;
        sb_d      = sb_q;
        if (adv_i) begin
            valid_d   = valid_i;
            rem_d     = fits ? trial : {rem_i[DW-1:0], acc_i[ZW-1]};
            acc_d     = {acc_i[ZW-2:0], fits};
            divisor_d = divisor_i;
            sb_d      = sb_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        rem_q     <= rem_d;
        acc_q     <= acc_d;
        divisor_q <= divisor_d;
        sb_q      <= sb_d;
    end

    assign valid_o   = valid_q;
    assign rem_o     = rem_q;
    assign acc_o     = acc_q;
    assign divisor_o = divisor_q;
    assign sb_o      = sb_q;

endmodule

// File: rtl/qnr_pipe_divider.sv
// Fully pipelined signed/unsigned divider: magnitude input stage, Z_WIDTH restoring stages,
// and a rounding/sign-restore output stage, all advanced by one global stall signal.
module qnr_pipe_divider
    import qnr_div_pkg::*;
#(
    parameter int unsigned Z_WIDTH = DEF_Z_WIDTH,
    parameter int unsigned D_WIDTH = DEF_D_WIDTH,
    parameter int unsigned TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Z_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    input  logic               round_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Z_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               div_zero,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned SBW = TAG_W + SB_FLAGS;
    localparam logic [Z_WIDTH-1:0] QMaxPos = {1'b0, {(Z_WIDTH-1){1'b1}}};
    localparam logic [Z_WIDTH-1:0] QMinNeg = {1'b1, {(Z_WIDTH-1){1'b0}}};

    logic adv;

    logic               in_neg;
    logic [Z_WIDTH-1:0] in_mag;
    logic               s0_valid_d, s0_valid_q;
    logic [Z_WIDTH-1:0] s0_acc_d, s0_acc_q;
    logic [D_WIDTH-1:0] s0_dvs_d, s0_dvs_q;
    logic [SBW-1:0]     s0_sb_d, s0_sb_q;

    // Index k is the input of restoring stage k; index Z_WIDTH feeds the output stage.
    logic [Z_WIDTH:0]              vld_c;
    logic [Z_WIDTH:0][D_WIDTH:0]   rem_c;
    logic [Z_WIDTH:0][Z_WIDTH-1:0] acc_c;
    logic [Z_WIDTH:0][D_WIDTH-1:0] dvs_c;
    logic [Z_WIDTH:0][SBW-1:0]     sb_c;

    logic               f_dz, f_neg, f_nz, f_rnd_up;
    logic [D_WIDTH+1:0] f_rem2;
    logic [Z_WIDTH-1:0] f_mag_r, f_q;
    logic               out_valid_d, out_valid_q;
    logic [Z_WIDTH-1:0] quotient_d, quotient_q;
    logic [D_WIDTH-1:0] remainder_d, remainder_q;
    logic               div_zero_d, div_zero_q;
    logic [TAG_W-1:0]   out_tag_d, out_tag_q;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    always_comb begin
        // -2^(Z_WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
        in_neg = dividend[Z_WIDTH-1];
        in_mag = in_neg ? -dividend : dividend;

        s0_valid_d = s0_valid_q;
        s0_acc_d   = s0_acc_q;
        s0_dvs_d   = s0_dvs_q;
        s0_sb_d    = s0_sb_q;
        if (adv) begin
            s0_valid_d = in_valid;
            s0_acc_d   = in_mag;
            s0_dvs_d   = divisor;
            s0_sb_d    = {in_tag, round_mode, in_neg, |in_mag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
        end
        s0_acc_q <= s0_acc_d;
        s0_dvs_q <= s0_dvs_d;
        s0_sb_q  <= s0_sb_d;
    end

    assign vld_c[0] = s0_valid_q;
    assign rem_c[0] = '0;
    assign acc_c[0] = s0_acc_q;
    assign dvs_c[0] = s0_dvs_q;
    assign sb_c[0]  = s0_sb_q;

    for (genvar k = 0; k < Z_WIDTH; k++) begin : g_stage
        qnr_div_stage #(
            .ZW  (Z_WIDTH),
            .DW  (D_WIDTH),
            .SBW (SBW)
        ) u_stage (
            .clk_i     (clk),
            .rst_i     (rst),
            .adv_i     (adv),
            .valid_i   (vld_c[k]),
            .rem_i     (rem_c[k]),
            .acc_i     (acc_c[k]),
            .divisor_i (dvs_c[k]),
            .sb_i      (sb_c[k]),
            .valid_o   (vld_c[k+1]),
            .rem_o     (rem_c[k+1]),
            .acc_o     (acc_c[k+1]),
            .divisor_o (dvs_c[k+1]),
            .sb_o      (sb_c[k+1])
        );
    end

    always_comb begin
        f_dz     = (dvs_c[Z_WIDTH] == '0);
        f_neg    = sb_c[Z_WIDTH][1];
        f_nz     = sb_c[Z_WIDTH][0];
        f_rem2   = {rem_c[Z_WIDTH], 1'b0};
        f_rnd_up = (round_mode_e'(sb_c[Z_WIDTH][2]) == ROUND) &&
                   (f_rem2 >= {2'b00, dvs_c[Z_WIDTH]});
        f_mag_r  = acc_c[Z_WIDTH] + {{(Z_WIDTH-1){1'b0}}, f_rnd_up};
        f_q      = f_neg ? -f_mag_r : f_mag_r;
        if (f_dz) begin
            f_q = !f_nz ? '0 : (f_neg ? QMinNeg : QMaxPos);
        end

        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        out_tag_d   = out_tag_q;
        if (adv) begin
            out_valid_d = vld_c[Z_WIDTH];
            quotient_d  = f_q;
            remainder_d = f_dz ? '0 : rem_c[Z_WIDTH][D_WIDTH-1:0];
            div_zero_d  = f_dz;
            out_tag_d   = sb_c[Z_WIDTH][SBW-1 -: TAG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_qnr_pipe_divider.sv
// Scoreboard bench for qnr_pipe_divider: directed corner cases, stalled random traffic, reset flush.
module tb_qnr_pipe_divider;

    localparam int unsigned ZW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 4;

    typedef struct packed {
        logic [ZW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [ZW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          round_mode = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [ZW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_zero;
    logic [TW-1:0] out_tag;

    int   total = 0;
    int   bad = 0;
    bit   stall_en = 1'b0;
    int   cyc = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    qnr_pipe_divider #(
        .Z_WIDTH (ZW),
        .D_WIDTH (DW),
        .TAG_W   (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .round_mode (round_mode),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero),
        .out_tag    (out_tag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [ZW-1:0] q, input logic [DW-1:0] r, input logic dz,
                                input logic [TW-1:0] tg);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.tag = tg;
        return e;
    endfunction

    // Integer reference model, independent of the bit-serial structure.
    function automatic exp_t model(input logic [ZW-1:0] a, input logic [DW-1:0] b,
                                   input logic rm, input logic [TW-1:0] tg);
        exp_t e;
        int sa, mag, q, rr;
        sa = int'($signed(a));
        mag = (sa < 0) ? -sa : sa;
        e.tag = tg;
        if (b == 0) begin
            e.dz = 1'b1;
            e.r = '0;
            if (sa == 0) q = 0;
            else if (sa > 0) q = 32767;
            else q = -32768;
        end else begin
            e.dz = 1'b0;
            q = mag / int'(b);
            rr = mag % int'(b);
            if (rm && (2 * rr >= int'(b))) q++;
            if (sa < 0) q = -q;
            e.r = rr[DW-1:0];
        end
        e.q = q[ZW-1:0];
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid still high.
    task automatic send(input logic [ZW-1:0] a, input logic [DW-1:0] b, input logic rm,
                        input logic [TW-1:0] tg, input exp_t e);
        bit acc;
        dividend = a; divisor = b; round_mode = rm; in_tag = tg; in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        chk("accept", 32'(acc), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (sb_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            out_ready = !stall_en || ((cyc % 6) < 3);
        end
    end

    initial begin : monitor
        exp_t e;
        exp_t hv;
        bit   held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid", 32'(out_valid), 1);
                    chk("stall_q", 32'(quotient), 32'(hv.q));
                    chk("stall_r", 32'(remainder), 32'(hv.r));
                    chk("stall_dz", 32'(div_zero), 32'(hv.dz));
                    chk("stall_tag", 32'(out_tag), 32'(hv.tag));
                end
                if (out_valid && out_ready) begin
                    chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("quotient", 32'(quotient), 32'(e.q));
                        chk("remainder", 32'(remainder), 32'(e.r));
                        chk("div_zero", 32'(div_zero), 32'(e.dz));
                        chk("out_tag", 32'(out_tag), 32'(e.tag));
                    end
                end
                held = out_valid && !out_ready;
                hv = mk(quotient, remainder, div_zero, out_tag);
            end
        end
    end

    initial begin : main
        int lat;
        logic [ZW-1:0] ra;
        logic [DW-1:0] rb;
        logic          rm;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_quotient", 32'(quotient), 0);
        chk("rst_remainder", 32'(remainder), 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_div_zero", 32'(div_zero), 0);

        // 100/7 with latency measured from the cycle the operands are presented.
        dividend = 16'd100; divisor = 8'd7; round_mode = 1'b0; in_tag = 4'd3; in_valid = 1'b1;
        chk("lat_in_ready", 32'(in_ready), 1);
        sb_q.push_back(mk(16'd14, 8'd2, 1'b0, 4'd3));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 18);

        send(16'hFF9B, 8'd2,   1'b1, 4'd1,  mk(16'hFFCD, 8'd1,   1'b0, 4'd1));
        send(16'hFF9B, 8'd2,   1'b0, 4'd2,  mk(16'hFFCE, 8'd1,   1'b0, 4'd2));
        send(16'hFFFD, 8'd7,   1'b0, 4'd4,  mk(16'h0000, 8'd3,   1'b0, 4'd4));
        send(16'h7FFF, 8'd1,   1'b0, 4'd5,  mk(16'h7FFF, 8'd0,   1'b0, 4'd5));
        send(16'h8000, 8'd1,   1'b0, 4'd6,  mk(16'h8000, 8'd0,   1'b0, 4'd6));
        send(16'h8000, 8'd255, 1'b1, 4'd7,  mk(16'hFF7F, 8'd128, 1'b0, 4'd7));
        send(16'h0005, 8'd0,   1'b0, 4'd8,  mk(16'h7FFF, 8'd0,   1'b1, 4'd8));
        send(16'hFFFB, 8'd0,   1'b1, 4'd9,  mk(16'h8000, 8'd0,   1'b1, 4'd9));
        send(16'h0000, 8'd0,   1'b1, 4'd10, mk(16'h0000, 8'd0,   1'b1, 4'd10));
        drain();

        // Back-to-back random traffic while the sink stalls in 3-cycle bursts.
        stall_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = ZW'($urandom);
            rb = (i % 10 == 9) ? 8'd0 : DW'($urandom_range(1, 255));
            rm = 1'($urandom_range(0, 1));
            send(ra, rb, rm, i[TW-1:0], model(ra, rb, rm, i[TW-1:0]));
        end
        drain();
        stall_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset flush: three operations in flight, reset, nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            ra = ZW'($urandom);
            rb = DW'($urandom_range(1, 255));
            send(ra, rb, 1'b0, 4'(i), model(ra, rb, 1'b0, 4'(i)));
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("flush_out_valid", 32'(out_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qnr_pipe_divider.md
QNR_PIPE_DIVIDER -- requirements
Module: qnr_pipe_divider

Interface
REQ-001 Parameter Z_WIDTH, default 16: signed dividend width and quotient width (range 4..32).
REQ-002 Parameter D_WIDTH, default 8: unsigned divisor width and remainder width (range 2..Z_WIDTH).
REQ-003 Parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 in_valid  in  1: operand set presented.
REQ-007 in_ready  out  1: operand set accepted when in_valid && in_ready.
REQ-008 dividend  in  Z_WIDTH: two's-complement dividend.
REQ-009 divisor  in  D_WIDTH: unsigned divisor.
REQ-010 round_mode  in  1: 0 = truncate toward zero, 1 = round half away from zero; sampled with the operands.
REQ-011 in_tag  in  TAG_W: sideband, returned unchanged with the result.
REQ-012 out_valid  out  1: result presented.
REQ-013 out_ready  in  1: result consumed when out_valid && out_ready.
REQ-014 quotient  out  Z_WIDTH: signed quotient.
REQ-015 remainder  out  D_WIDTH: unsigned magnitude remainder, before rounding.
REQ-016 div_zero  out  1: divisor was zero for this result.
REQ-017 out_tag  out  TAG_W: tag of this result.

Function
REQ-018 Pipeline: input stage (sign strip, magnitude), Z_WIDTH restoring-division stages of one quotient bit each, output stage (round, sign restore); latency Z_WIDTH+2 cycles from acceptance to out_valid with no stall.
REQ-019 Global advance adv = !out_valid || out_ready; in_ready = adv; every stage register, including valid bits, loads only when adv=1.
REQ-020 Throughput: one operation per cycle while adv=1; results emerge in acceptance order; none dropped or duplicated.
REQ-021 Stage k: trial = {rem_k, next dividend bit} - divisor; if trial >= 0, keep trial and emit quotient bit 1; otherwise keep partial remainder and emit 0; partial remainder is D_WIDTH+1 bits wide.
REQ-022 Magnitude of -2^(Z_WIDTH-1) is carried as Z_WIDTH-bit unsigned 2^(Z_WIDTH-1); quotient -2^(Z_WIDTH-1) is representable and produced without overflow.
REQ-023 round_mode=1: magnitude incremented when 2*remainder >= divisor; sign then applied to the rounded magnitude.
REQ-024 Sign: quotient negative iff dividend negative and magnitude nonzero; zero quotient is never reported negative.
REQ-025 Divisor 0: div_zero=1, remainder=0; quotient 0 if dividend 0, 2^(Z_WIDTH-1)-1 if dividend positive, -2^(Z_WIDTH-1) if negative; round_mode ignored.
REQ-026 Outputs quotient, remainder, div_zero, out_tag stable while out_valid && !out_ready.
REQ-027 in_valid with in_ready=0: operands are not captured; the source must hold them.

Reset
REQ-028 rst=1 at a rising edge clears all stage valid bits; next cycle out_valid=0, in_ready=1; quotient, remainder, out_tag = 0, div_zero=0.
REQ-029 Reset mid-operation discards all in-flight operations; no result from before reset appears afterwards.
REQ-030 Datapath registers other than valid bits and outputs need no reset.

Structure
REQ-031 Package qnr_div_pkg holds round_mode_e (TRUNC=0, ROUND=1) and default width constants.
REQ-032 One sub-module qnr_div_stage (one restoring iteration plus its registers) instantiated Z_WIDTH times by generate.

Verification (Z_WIDTH=16, D_WIDTH=8)
REQ-033 100/7, TRUNC, tag 3 -> quotient 14, remainder 2, div_zero 0, out_tag 3, out_valid exactly 18 cycles after acceptance.
REQ-034 -101/2 ROUND -> -51, remainder 1; -101/2 TRUNC -> -50; -3/7 TRUNC -> 0 (not negative).
REQ-035 32767/1 -> 32767; -32768/1 -> -32768; -32768/255 ROUND -> -129 (remainder 128).
REQ-036 5/0 -> 32767, div_zero 1; -5/0 -> -32768, div_zero 1; 0/0 -> 0, div_zero 1.
REQ-037 40 back-to-back random ops, out_ready low for 3-cycle bursts -> all 40 results in order, tags match, outputs stable during stall, reference-model equal.
REQ-038 rst asserted 5 cycles after 3 acceptances -> out_valid 0 for the following 20 cycles with no new input.
